// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard decoder.
//
// Contents:
//   - PREFIX_EXT / PREFIX_BRK : the E0 (extended) and F0 (break) prefix bytes
//   - SC_*                    : the scancodes of the keys we track
//   - KEY_*                   : bit positions of those keys in key_state
//   - MAP_SIZE                : number of entries in the key map
//   - rx_state_t              : receiver FSM state encoding
//   - key_code / key_ext      : key map lookup, index -> (scancode, needs E0)
package ps2_pkg;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_R      = 8'h2D;
    localparam logic [7:0] SC_P      = 8'h4D;

    localparam int KEY_W     = 0;
    localparam int KEY_A     = 1;
    localparam int KEY_S     = 2;
    localparam int KEY_D     = 3;
    localparam int KEY_UP    = 4;
    localparam int KEY_LEFT  = 5;
    localparam int KEY_DOWN  = 6;
    localparam int KEY_RIGHT = 7;
    localparam int KEY_SPACE = 8;
    localparam int KEY_ENTER = 9;
    localparam int KEY_ESC   = 10;
    localparam int KEY_R     = 11;
    localparam int KEY_P     = 12;

    localparam int MAP_SIZE = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Scancode of the key at a given key_state index.
    function automatic logic [7:0] key_code(input int idx);
        case (idx)
            KEY_W:     key_code = SC_W;
            KEY_A:     key_code = SC_A;
            KEY_S:     key_code = SC_S;
            KEY_D:     key_code = SC_D;
            KEY_UP:    key_code = SC_UP;
            KEY_LEFT:  key_code = SC_LEFT;
            KEY_DOWN:  key_code = SC_DOWN;
            KEY_RIGHT: key_code = SC_RIGHT;
            KEY_SPACE: key_code = SC_SPACE;
            KEY_ENTER: key_code = SC_ENTER;
            KEY_ESC:   key_code = SC_ESC;
            KEY_R:     key_code = SC_R;
            KEY_P:     key_code = SC_P;
            default:   key_code = 8'h00;
        endcase
    endfunction

    // Whether the key at a given index is sent with the E0 prefix.
    function automatic logic key_ext(input int idx);
        key_ext = (idx >= KEY_UP) && (idx <= KEY_RIGHT);
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchroniser and glitch filter for one raw PS/2 line.
//
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset (line resets to the idle-high level)
//   raw   : asynchronous line from the keyboard
//   level : filtered level; follows raw only after FILTER_LEN consecutive
//           synchronised samples that disagree with the current level
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] run_cnt;

    // Two-flop synchroniser followed by a run-length filter. The counter
    // tracks how many samples in a row differ from the accepted level; any
    // sample agreeing with the accepted level restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta    <= 1'b1;
            sync    <= 1'b1;
            level   <= 1'b1;
            run_cnt <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
                level   <= sync;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scancode decoder.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   ps2_clk     : raw keyboard clock
//   ps2_data    : raw keyboard data
//   key_state   : held pressed (1) / released (0) level per mapped key
//   ev_valid    : one-entry event register holds an event
//   ev_ready    : consumer accepts the held event
//   ev_code     : scancode of the event, prefixes removed
//   ev_ext      : event carried the E0 prefix
//   ev_brk      : event is a key release (F0 prefix)
//   frame_err   : one-cycle pulse on parity/stop error or frame timeout
//   ev_overflow : one-cycle pulse when an event is dropped (register full)
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int NUM_KEYS    = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [7:0]          ev_code,
    output logic                ev_ext,
    output logic                ev_brk,
    output logic                frame_err,
    output logic                ev_overflow
);

    localparam int TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int MAP_LIMIT = (NUM_KEYS < MAP_SIZE) ? NUM_KEYS : MAP_SIZE;

    logic clk_f, data_f, clk_f_prev, strobe;

    rx_state_t        state, state_n;
    logic [7:0]       shift_reg, shift_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [TO_W-1:0]  to_cnt, to_cnt_n;
    logic             par_ok, par_ok_n;
    logic             byte_valid, byte_valid_n;
    logic             frame_err_n;
    logic             ext_flag, brk_flag;
    logic             is_prefix, ev_form;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_clk),
        .level (clk_f)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_data),
        .level (data_f)
    );

    // The keyboard changes data while its clock is high, so the filtered
    // clock falling edge is the point where data is sampled.
    assign strobe = clk_f_prev & ~clk_f;

    // Receiver state register. byte_valid and frame_err are registered so the
    // decoder sees the byte the cycle after the stop-bit strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_f_prev <= 1'b1;
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            par_ok     <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_f_prev <= clk_f;
            state      <= state_n;
            shift_reg  <= shift_n;
            bit_cnt    <= bit_cnt_n;
            to_cnt     <= to_cnt_n;
            par_ok     <= par_ok_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // Frame sequencing. The timeout counter runs only inside a frame and is
    // cleared by every strobe; the parity verdict is stored in PARITY and
    // combined with the stop bit so a frame is judged as a whole in STOP.
    always_comb begin
        state_n      = state;
        shift_n      = shift_reg;
        bit_cnt_n    = bit_cnt;
        to_cnt_n     = to_cnt;
        par_ok_n     = par_ok;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        if (state != ST_IDLE) begin
            to_cnt_n = to_cnt + TO_W'(1);
        end
        if (strobe) begin
            to_cnt_n = '0;
            case (state)
                ST_IDLE: begin
                    if (!data_f) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end
                end
                ST_DATA: begin
                    shift_n   = {data_f, shift_reg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_ok_n = ^{shift_reg, data_f};
                    state_n  = ST_STOP;
                end
                ST_STOP: begin
                    state_n = ST_IDLE;
                    if (data_f && par_ok) begin
                        byte_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            state_n     = ST_IDLE;
            to_cnt_n    = '0;
            frame_err_n = 1'b1;
        end
    end

    assign is_prefix = (shift_reg == PREFIX_EXT) || (shift_reg == PREFIX_BRK);
    assign ev_form   = byte_valid && !is_prefix;

    // Prefix flags, event register and key levels. A full register that is
    // not being consumed keeps its contents and the new event is dropped,
    // but the key levels still track every event that forms.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            ev_valid    <= 1'b0;
            ev_code     <= '0;
            ev_ext      <= 1'b0;
            ev_brk      <= 1'b0;
            ev_overflow <= 1'b0;
            key_state   <= '0;
        end else begin
            ev_overflow <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_valid) begin
                if (shift_reg == PREFIX_EXT) begin
                    ext_flag <= 1'b1;
                end else if (shift_reg == PREFIX_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end

            if (ev_form) begin
                if (!ev_valid || ev_ready) begin
                    ev_valid <= 1'b1;
                    ev_code  <= shift_reg;
                    ev_ext   <= ext_flag;
                    ev_brk   <= brk_flag;
                end else begin
                    ev_overflow <= 1'b1;
                end
            end else if (ev_ready) begin
                ev_valid <= 1'b0;
            end

            for (int i = 0; i < MAP_LIMIT; i++) begin
                if (ev_form && shift_reg == key_code(i) && ext_flag == key_ext(i)) begin
                    key_state[i] <= ~brk_flag;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by
// randomised frames, all compared against a byte-level reference model.
module tb_ps2_key_decoder;

    localparam int FILT    = 4;
    localparam int TIMEOUT = 300;
    localparam int NKEYS   = 13;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ps2_clk = 1'b1;
    logic             ps2_data = 1'b1;
    logic [NKEYS-1:0] key_state;
    logic             ev_valid;
    logic             ev_ready = 1'b1;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_brk;
    logic             frame_err;
    logic             ev_overflow;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [NKEYS-1:0] model_keys = '0;
    logic             model_ext = 1'b0;
    logic             model_brk = 1'b0;
    int               exp_err = 0;
    int               exp_ovf = 0;
    logic [9:0]       exp_q[$];

    // Observed activity
    int               seen_err = 0;
    int               seen_ovf = 0;
    logic [9:0]       obs_q[$];

    // Key map as listed for the keyboard: {ext, code}
    logic [8:0] key_map [NKEYS] = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h175,
                                    9'h16B, 9'h172, 9'h174, 9'h029, 9'h05A,
                                    9'h076, 9'h02D, 9'h04D};

    ps2_key_decoder #(
        .FILTER_LEN  (FILT),
        .TIMEOUT_CYC (TIMEOUT),
        .NUM_KEYS    (NKEYS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_state   (key_state),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_ext      (ev_ext),
        .ev_brk      (ev_brk),
        .frame_err   (frame_err),
        .ev_overflow (ev_overflow)
    );

    always #5 clk = ~clk;

    // Record handshakes and error/overflow pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ev_valid && ev_ready) obs_q.push_back({ev_ext, ev_brk, ev_code});
            if (frame_err) seen_err++;
            if (ev_overflow) seen_ovf++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drives the first nbits bits of an 11-bit frame; bad_par flips parity.
    task automatic applyStimulus(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] frame;
        frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            repeat (10) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(posedge clk);
        end
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    // Byte-level model: prefixes set flags, other bytes form events.
    task automatic modelByte(input logic [7:0] b, input logic drop);
        if (b == 8'hE0) model_ext = 1'b1;
        else if (b == 8'hF0) model_brk = 1'b1;
        else begin
            for (int k = 0; k < NKEYS; k++)
                if (key_map[k] == {model_ext, b}) model_keys[k] = ~model_brk;
            if (drop) exp_ovf++;
            else exp_q.push_back({model_ext, model_brk, b});
            model_ext = 1'b0;
            model_brk = 1'b0;
        end
    endtask

    task automatic modelError();
        model_ext = 1'b0;
        model_brk = 1'b0;
        exp_err++;
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b, 1'b0, 11);
        modelByte(b, 1'b0);
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "_ev_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            checkOutput({tag, "_ev"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
        checkOutput({tag, "_keys"}, 32'(key_state), 32'(model_keys));
        checkOutput({tag, "_frame_err"}, 32'(seen_err), 32'(exp_err));
        checkOutput({tag, "_overflow"}, 32'(seen_ovf), 32'(exp_ovf));
    endtask

    task automatic checkResetOutputs(input string tag);
        @(negedge clk);
        checkOutput({tag, "_keys"}, 32'(key_state), 32'h0);
        checkOutput({tag, "_outs"}, {20'h0, ev_valid, ev_code, ev_ext, ev_brk, frame_err},
                    32'h0);
        checkOutput({tag, "_ovf"}, 32'(ev_overflow), 32'h0);
    endtask

    initial begin
        int r;
        logic [7:0] b;
        logic bad;

        repeat (5) @(posedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        // Single make
        sendByte(8'h1D);
        compareAll("make_1d");

        // Extended make then extended break of the same key
        sendByte(8'hE0);
        sendByte(8'h75);
        compareAll("make_up");
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        compareAll("break_up");

        // Bad parity
        applyStimulus(8'h1C, 1'b1, 11);
        modelError();
        compareAll("bad_parity");

        // Register full: second event is dropped, first held unchanged
        @(posedge clk); #1 ev_ready = 1'b0;
        sendByte(8'h1D);
        applyStimulus(8'h1B, 1'b0, 11);
        modelByte(8'h1B, 1'b1);
        @(negedge clk);
        checkOutput("hold_valid", 32'(ev_valid), 32'h1);
        checkOutput("hold_event", {22'h0, ev_ext, ev_brk, ev_code}, 32'h01D);
        checkOutput("hold_ovf", 32'(seen_ovf), 32'(exp_ovf));
        @(posedge clk); #1 ev_ready = 1'b1;
        repeat (5) @(posedge clk);
        compareAll("overflow");

        // Timeout after start + 4 data bits, then a clean frame
        sendByte(8'hE0);
        applyStimulus(8'h55, 1'b0, 5);
        repeat (TIMEOUT + 60) @(posedge clk);
        modelError();
        compareAll("timeout");
        sendByte(8'h23);
        compareAll("after_timeout");

        // Reset in the middle of a frame
        applyStimulus(8'h5A, 1'b0, 4);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        checkResetOutputs("mid_reset");
        model_keys = '0;
        model_ext = 1'b0;
        model_brk = 1'b0;
        obs_q.delete();
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        sendByte(8'h5A);
        compareAll("after_reset");

        // Randomised frames
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 20) b = 8'hE0;
            else if (r < 35) b = 8'hF0;
            else if (r < 80) b = key_map[$urandom_range(0, NKEYS - 1)][7:0];
            else b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            applyStimulus(b, bad, 11);
            if (bad) modelError();
            else modelByte(b, 1'b0);
            compareAll("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: consecutive equal synchronised samples needed to accept a ps2_clk/ps2_data level change.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 100000: clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned.
REQ-003 The block SHALL have parameter NUM_KEYS, default 13, range 1..16: width of key_state.
REQ-004 Port clk, input, 1: sole clock. The block has one clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port ps2_clk, input, 1: raw asynchronous keyboard clock.
REQ-007 Port ps2_data, input, 1: raw asynchronous keyboard data.
REQ-008 Port key_state, output, NUM_KEYS: held level per mapped key, 1 = pressed.
REQ-009 Port ev_valid, output, 1: event register holds an unconsumed event.
REQ-010 Port ev_ready, input, 1: consumer accepts the event.
REQ-011 Port ev_code, output, 8: scancode of the event (prefixes stripped).
REQ-012 Port ev_ext, output, 1: event carried the E0 prefix.
REQ-013 Port ev_brk, output, 1: event is a release (F0 prefix).
REQ-014 Port frame_err, output, 1: one-cycle pulse on parity, start, stop or timeout error.
REQ-015 Port ev_overflow, output, 1: one-cycle pulse when an event is dropped.

Function
REQ-016 ps2_clk and ps2_data SHALL each pass a 2-flop synchroniser, then a FILTER_LEN glitch filter; the filtered ps2_clk falling edge is the sample strobe.
REQ-017 Receiver FSM states: IDLE, DATA, PARITY, STOP. IDLE->DATA on strobe with data=0; strobe with data=1 in IDLE SHALL be ignored.
REQ-018 DATA SHALL shift in 8 bits LSB first, then go to PARITY. PARITY SHALL check odd parity over data+parity bit. STOP SHALL require data=1.
REQ-019 On a good frame the FSM SHALL return to IDLE and present the byte to the decoder in the cycle after the stop strobe. On a bad frame it SHALL return to IDLE, pulse frame_err, discard the byte and clear the E0/F0 flags.
REQ-020 In any non-IDLE state, TIMEOUT_CYC cycles without a strobe SHALL force IDLE, pulse frame_err and clear the flags.
REQ-021 Decoder: byte E0 sets ext_flag; byte F0 sets brk_flag. Any other byte forms an event {code, ext_flag, brk_flag}, then clears both flags. Prefixes alone produce no event.
REQ-022 Key map (index: ext,code): 0:0,1D; 1:0,1C; 2:0,1B; 3:0,23; 4:1,75; 5:1,6B; 6:1,72; 7:1,74; 8:0,29; 9:0,5A; 10:0,76; 11:0,2D; 12:0,4D. Indices >= NUM_KEYS or >12 SHALL be unused and read 0.
REQ-023 On an event matching index i < NUM_KEYS, key_state[i] SHALL be set (make) or cleared (break) one cycle after the event forms. Unmapped codes SHALL leave key_state unchanged. Repeated makes are idempotent.
REQ-024 The event register SHALL be one entry. It loads when empty, or when ev_valid&&ev_ready in the same cycle (simultaneous consume and load passes through with no bubble).
REQ-025 If an event forms while ev_valid=1 and ev_ready=0, the new event SHALL be dropped, ev_overflow SHALL pulse, and the held event SHALL stay unchanged. key_state SHALL still update.
REQ-026 ev_code, ev_ext and ev_brk SHALL remain stable while ev_valid=1 and ev_ready=0.

Reset
REQ-027 While rst=1: FSM=IDLE; shift register, bit count, timeout counter, filters=1 (idle bus), flags=0; key_state=0, ev_valid=0, ev_code=0, ev_ext=0, ev_brk=0, frame_err=0, ev_overflow=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first strobe after reset release SHALL be treated as a potential start bit.

Structure
REQ-029 The scancode constants, prefix codes E0/F0 and key-index constants SHALL reside in the shared package ps2_pkg.
REQ-030 The synchroniser+filter SHALL be a sub-module ps2_filter, instantiated twice.

Verification
REQ-031 Good frame 0x1D with correct parity, ev_ready=1 -> ev_valid pulses with code 1D, ext 0, brk 0; key_state[0]=1.
REQ-032 Sequence E0,F0,75 -> one event with code 75, ext 1, brk 1; key_state[4] cleared; no events for the prefixes.
REQ-033 Frame 0x1C with bad parity -> frame_err pulse, no event, key_state unchanged.
REQ-034 ev_ready=0, send 0x1D then 0x1B -> first event held stable, ev_overflow pulses once, key_state[0]=1 and key_state[2]=1.
REQ-035 Stop ps2_clk after 4 data bits -> after TIMEOUT_CYC cycles frame_err pulses; then a full 0x23 frame decodes correctly.
REQ-036 Assert rst mid-frame, then send 0x5A -> all outputs are 0 during reset; after reset, event 5A and key_state[9]=1.
